// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
// Used by param_reg_bank and reg_bank_rd_pipe.
package reg_bank_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Even parity: the stored bit makes the 9-bit total even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/reg_bank_rd_pipe.sv
// Read-return delay line: RD_LAT stages of data, valid strobe and parity error.
// Data stages load only with their valid, so the output holds between strobes.
module reg_bank_rd_pipe
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              perr_in,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic              perr
);

  localparam int LAT =
    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
    (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT;

  logic [LAT-1:0]    vld_q;
  logic [LAT-1:0]    perr_q;
  logic [DATA_W-1:0] data_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      perr_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= vld_in;
      perr_q[0] <= vld_in & perr_in;
      if (vld_in) begin
        data_q[0] <= data_in;
      end
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        perr_q[i] <= perr_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign vld  = vld_q[LAT-1];
  assign perr = perr_q[LAT-1];
  assign data = data_q[LAT-1];

endmodule

// File: rtl/param_reg_bank.sv
// Parametrised single-port register bank with byte enables, write-first bypass
// and post-reset clear. Optional per-byte parity storage: REG_BANK_PARITY_EN.
module param_reg_bank
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ren,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic                rdy,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_vld,
  output logic                par_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  state_e            state;
  state_e            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] new_word;
  logic [DATA_W-1:0] rd_word;
  logic              acc_rd;
  logic              acc_wr;
  logic              rd_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nx = cnt + ADDR_W'(1);
        if (&cnt) begin
          state_nx = IDLE;
        end
      end
      IDLE: begin
        cnt_nx = '0;
      end
    endcase
  end

  assign rdy    = (state == IDLE);
  assign acc_rd = rdy & ren;
  assign acc_wr = rdy & wen;

  assign old_word = mem[addr];

  always_comb begin
    new_word = old_word;
    for (int b = 0; b < NB; b++) begin
      if (wbe[b]) begin
        new_word[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Same-cycle write to the read address returns the merged new word.
  assign rd_word = acc_wr ? new_word : old_word;

  always_ff @(posedge clk) begin
    if (!rdy) begin
      mem[cnt] <= INIT_VAL;
    end else if (acc_wr) begin
      mem[addr] <= new_word;
    end
  end

`ifdef REG_BANK_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] old_par;
  logic [NB-1:0] new_par;
  logic [NB-1:0] rd_par;
  logic [NB-1:0] init_par;

  assign old_par = par_mem[addr];

  always_comb begin
    new_par  = old_par;
    init_par = '0;
    for (int b = 0; b < NB; b++) begin
      init_par[b] = byte_parity(INIT_VAL[8*b +: 8]);
      if (wbe[b]) begin
        new_par[b] = byte_parity(wdata[8*b +: 8]);
      end
    end
  end

  assign rd_par = acc_wr ? new_par : old_par;

  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < NB; b++) begin
      rd_perr = rd_perr |
        (rd_par[b] ^ byte_parity(rd_word[8*b +: 8]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rdy) begin
      par_mem[cnt] <= init_par;
    end else if (acc_wr) begin
      par_mem[addr] <= new_par;
    end
  end
`else
  assign rd_perr = 1'b0;
`endif

  reg_bank_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_in  (acc_rd),
    .data_in (rd_word),
    .perr_in (rd_perr),
    .vld     (rd_vld),
    .data    (data_out),
    .perr    (par_err)
  );

endmodule

// File: tb/tb_param_reg_bank.sv
// Bench for param_reg_bank: RD_LAT=1 and RD_LAT=2 instances on shared inputs,
// fixed vector table, hand sequences and a random run against an array model.
module tb_param_reg_bank;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          ren   = 1'b0;
  logic          wen   = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    wbe   = '0;

  logic          rdy1, rdy2, vld1, vld2, pe1, pe2;
  logic [DW-1:0] do1, do2;

  always #5 clk = ~clk;

  param_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .INIT_VAL('0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .wbe(wbe), .rdy(rdy1), .data_out(do1),
    .rd_vld(vld1), .par_err(pe1)
  );

  param_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .INIT_VAL('0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ren(ren), .wen(wen), .addr(addr),
    .wdata(wdata), .wbe(wbe), .rdy(rdy2), .data_out(do2),
    .rd_vld(vld2), .par_err(pe2)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: plain array plus expected output state per latency.
  logic [DW-1:0] mref [DEPTH];
  int            clear_left;
  logic          e1_vld, e1_pe, s2_vld, s2_pe, e2_vld, e2_pe;
  logic [DW-1:0] e1_d, s2_d, e2_d;
  logic          bad_en;
  logic [AW-1:0] bad_a;

  typedef struct {
    logic          w;
    logic          r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    be;
    logic          ev;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    e1_vld = 0; e1_pe = 0; e1_d = '0;
    s2_vld = 0; s2_pe = 0; s2_d = '0;
    e2_vld = 0; e2_pe = 0; e2_d = '0;
    bad_en = 0; bad_a = '0;
    for (int i = 0; i < DEPTH; i++) mref[i] = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rdy1", rdy1, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_do1",  do1,  0);
    chk("rst_pe1",  pe1,  0);
    chk("rst_rdy2", rdy2, 0);
    chk("rst_vld2", vld2, 0);
    chk("rst_do2",  do2,  0);
    chk("rst_pe2",  pe2,  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] be);
    logic          rv;
    logic          rpe;
    logic [DW-1:0] word;
    wen = w; ren = r; addr = a; wdata = d; wbe = be;
    rv   = r && (clear_left == 0);
    rpe  = rv && bad_en && (a == bad_a);
    word = mref[a];
    if (w && clear_left == 0) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) word[8*b +: 8] = d[8*b +: 8];
      mref[a] = word;
    end
    @(posedge clk);
    #1;
    e2_vld = s2_vld; e2_pe = s2_pe;
    if (s2_vld) e2_d = s2_d;
    s2_vld = rv; s2_pe = rpe; s2_d = word;
    e1_vld = rv; e1_pe = rpe;
    if (rv) e1_d = word;
    if (clear_left > 0) clear_left--;
    chk("rdy1", rdy1, clear_left == 0);
    chk("rdy2", rdy2, clear_left == 0);
    chk("vld1", vld1, e1_vld);
    chk("data1", do1, e1_d);
    chk("perr1", pe1, e1_pe);
    chk("vld2", vld2, e2_vld);
    chk("data2", do2, e2_d);
    chk("perr2", pe2, e2_pe);
    wen = 0; ren = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 2'b00);
  endtask

  initial begin
    tbl[0] = '{1, 0, 4'd3, 16'hA5C3, 2'b01, 0, 16'h0000};
    tbl[1] = '{0, 1, 4'd3, 16'h0000, 2'b00, 1, 16'h00C3};
    tbl[2] = '{1, 0, 4'd3, 16'h1200, 2'b10, 0, 16'h00C3};
    tbl[3] = '{0, 1, 4'd3, 16'h0000, 2'b00, 1, 16'h12C3};
    tbl[4] = '{1, 1, 4'd7, 16'hBEEF, 2'b11, 1, 16'hBEEF};
    tbl[5] = '{1, 0, 4'd3, 16'hFFFF, 2'b00, 0, 16'hBEEF};
    tbl[6] = '{0, 1, 4'd3, 16'h0000, 2'b00, 1, 16'h12C3};

    apply_reset();

    // Clear window: rdy low for exactly DEPTH edges.
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, AW'(i), '0, 2'b00);
    idle(2);

    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].be);
      chk("tbl_vld", vld1, tbl[i].ev);
      chk("tbl_data", do1, tbl[i].ed);
    end
    idle(2);

    // Back-to-back reads on the two-stage instance.
    cycle(0, 1, 4'd0, '0, 2'b00);
    chk("lat2_first_edge", vld2, 0);
    cycle(0, 1, 4'd1, '0, 2'b00);
    cycle(0, 1, 4'd2, '0, 2'b00);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 1'($urandom), AW'($urandom_range(0, DEPTH-1)),
            DW'($urandom), 2'($urandom));
    end
    idle(2);

    // Reset with a read in flight on both instances.
    cycle(1, 0, 4'd5, 16'h5A5A, 2'b11);
    cycle(0, 1, 4'd5, '0, 2'b00);
    cycle(0, 1, 4'd5, '0, 2'b00);
    apply_reset();

    // Reset again part way through the clear.
    for (int i = 0; i < 5; i++) cycle(1, 1, AW'(i), 16'hFFFF, 2'b11);
    apply_reset();
    idle(DEPTH);
    for (int i = 0; i < 6; i++) cycle(0, 1, AW'(i), '0, 2'b00);
    idle(2);

`ifdef REG_BANK_PARITY_EN
    cycle(1, 0, 4'd9, 16'h3C3C, 2'b11);
    dut1.mem[9] = dut1.mem[9] ^ 16'h0001;
    dut2.mem[9] = dut2.mem[9] ^ 16'h0001;
    mref[9] = mref[9] ^ 16'h0001;
    bad_en = 1;
    bad_a  = 4'd9;
    cycle(0, 1, 4'd9, '0, 2'b00);
    chk("par_flip1", pe1, 1);
    cycle(0, 1, 4'd8, '0, 2'b00);
    chk("par_flip2", pe2, 1);
    idle(2);
    bad_en = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
